// File: rtl/fifo_ovf_monitor.sv
// Overflow monitor for a bank of router-interface FIFOs: per-cycle flags, sticky flags with
// interrupt, saturating event counters, occupancy high-water marks, first-overflow latch and read-out.
module fifo_ovf_monitor #(
  parameter  int N_CH       = 64,
  parameter  int pckg_sz    = 40,
  parameter  int fifo_depth = 4,
  parameter  int CNT_W      = 16,
  localparam int CW         = $clog2(fifo_depth) + 1,
  localparam int IW         = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         tap_push,
  input  logic [N_CH*CW-1:0]      tap_count,
  input  logic [N_CH*pckg_sz-1:0] tap_data,
  input  logic [N_CH-1:0]         irq_mask,
  input  logic                    clr,
  input  logic [IW-1:0]           rd_ch,
  output logic [N_CH-1:0]         ovf_now,
  output logic [N_CH-1:0]         ovf_sticky,
  output logic                    irq,
  output logic                    first_vld,
  output logic [IW-1:0]           first_ch,
  output logic [pckg_sz-1:0]      first_data,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic [CW-1:0]           rd_hwm,
  output logic [pckg_sz-1:0]      rd_data
);

  localparam logic [CW-1:0]    FULL    = CW'(fifo_depth);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]    ev;
  logic [N_CH-1:0]    ovf_now_q;
  logic [N_CH-1:0]    sticky_q, sticky_d;
  logic               irq_q, irq_d;
  logic               first_vld_q, first_vld_d;
  logic [IW-1:0]      first_ch_q, first_ch_d;
  logic [pckg_sz-1:0] first_data_q, first_data_d;
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [CW-1:0]      hwm_q [N_CH];
  logic [CW-1:0]      hwm_d [N_CH];
  logic [pckg_sz-1:0] last_q [N_CH];
  logic [pckg_sz-1:0] last_d [N_CH];
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]      rd_hwm_q, rd_hwm_d;
  logic [pckg_sz-1:0] rd_data_q, rd_data_d;
  logic               take_first;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ev[i] = tap_push[i] && (tap_count[i*CW +: CW] == FULL);
    end
  end

  // Per-channel state: clr wipes first, then this cycle's taps are applied on top.
  // NOTE: always_comb uses blocking '=' so later statements see the earlier partial results;
  // every target gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = clr ? '0 : cnt_q[i];
      hwm_d[i]  = clr ? '0 : hwm_q[i];
      last_d[i] = clr ? '0 : last_q[i];
      if (tap_count[i*CW +: CW] > hwm_d[i]) hwm_d[i] = tap_count[i*CW +: CW];
      if (ev[i]) begin
        last_d[i] = tap_data[i*pckg_sz +: pckg_sz];
        if (cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + 1'b1;
      end
    end
    sticky_d = (clr ? '0 : sticky_q) | ev;
    irq_d    = |(sticky_d & irq_mask);
  end

  // Descending scan so the lowest-index event channel is the one left standing.
  always_comb begin
    first_vld_d  = clr ? 1'b0 : first_vld_q;
    first_ch_d   = clr ? '0   : first_ch_q;
    first_data_d = clr ? '0   : first_data_q;
    take_first   = !first_vld_d && (|ev);
    if (take_first) begin
      first_vld_d = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ev[i]) begin
          first_ch_d   = IW'(i);
          first_data_d = tap_data[i*pckg_sz +: pckg_sz];
        end
      end
    end
  end

  always_comb begin
    rd_cnt_d  = '0;
    rd_hwm_d  = '0;
    rd_data_d = '0;
    if (int'(rd_ch) < N_CH) begin
      rd_cnt_d  = cnt_d[rd_ch];
      rd_hwm_d  = hwm_d[rd_ch];
      rd_data_d = last_d[rd_ch];
    end
  end

  // NOTE: the per-channel arrays are plain flops, not RAM, so they take the async reset
  // like every other register; a RAM-style array without reset would leave stale counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_now_q    <= '0;
      sticky_q     <= '0;
      irq_q        <= 1'b0;
      first_vld_q  <= 1'b0;
      first_ch_q   <= '0;
      first_data_q <= '0;
      rd_cnt_q     <= '0;
      rd_hwm_q     <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        hwm_q[i]  <= '0;
        last_q[i] <= '0;
      end
    end else begin
      ovf_now_q    <= ev;
      sticky_q     <= sticky_d;
      irq_q        <= irq_d;
      first_vld_q  <= first_vld_d;
      first_ch_q   <= first_ch_d;
      first_data_q <= first_data_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_hwm_q     <= rd_hwm_d;
      rd_data_q    <= rd_data_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hwm_q[i]  <= hwm_d[i];
        last_q[i] <= last_d[i];
      end
    end
  end

  assign ovf_now    = ovf_now_q;
  assign ovf_sticky = sticky_q;
  assign irq        = irq_q;
  assign first_vld  = first_vld_q;
  assign first_ch   = first_ch_q;
  assign first_data = first_data_q;
  assign rd_cnt     = rd_cnt_q;
  assign rd_hwm     = rd_hwm_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_fifo_ovf_monitor.sv
// Scoreboard bench for fifo_ovf_monitor: a behavioural model predicts every post-edge output set,
// a separate monitor pops and compares; directed scenarios are followed by randomized traffic.
module tb_fifo_ovf_monitor;

  localparam int N_CH    = 64;
  localparam int PW      = 40;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CW      = 3;
  localparam int IW      = 6;
  localparam int CNT_MAX = 15;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N_CH-1:0]      tap_push = '0;
  logic [N_CH*CW-1:0]   tap_count = '0;
  logic [N_CH*PW-1:0]   tap_data = '0;
  logic [N_CH-1:0]      irq_mask = '0;
  logic                 clr = 1'b0;
  logic [IW-1:0]        rd_ch = '0;
  logic [N_CH-1:0]      ovf_now, ovf_sticky;
  logic                 irq, first_vld;
  logic [IW-1:0]        first_ch;
  logic [PW-1:0]        first_data, rd_data;
  logic [CNT_W-1:0]     rd_cnt;
  logic [CW-1:0]        rd_hwm;

  fifo_ovf_monitor #(.N_CH(N_CH), .pckg_sz(PW), .fifo_depth(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .tap_push(tap_push), .tap_count(tap_count), .tap_data(tap_data),
    .irq_mask(irq_mask), .clr(clr), .rd_ch(rd_ch), .ovf_now(ovf_now), .ovf_sticky(ovf_sticky),
    .irq(irq), .first_vld(first_vld), .first_ch(first_ch), .first_data(first_data),
    .rd_cnt(rd_cnt), .rd_hwm(rd_hwm), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0] now;
    logic [N_CH-1:0] sticky;
    logic            irq;
    logic            fv;
    int              fch;
    logic [PW-1:0]   fdata;
    int              rcnt;
    int              rhwm;
    logic [PW-1:0]   rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus for the next edge.
  bit              rst_in = 1'b0;
  bit              clr_in = 1'b0;
  bit              push_in [N_CH];
  int              count_in [N_CH];
  logic [PW-1:0]   data_in [N_CH];
  logic [N_CH-1:0] mask_in = '0;
  int              rd_in = 0;

  // Reference state, kept as plain integers and flags.
  bit              m_sticky [N_CH];
  int              m_cnt [N_CH];
  int              m_hwm [N_CH];
  logic [PW-1:0]   m_last [N_CH];
  bit              m_fv;
  int              m_fch;
  logic [PW-1:0]   m_fdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit all);
    for (int i = 0; i < N_CH; i++) begin
      m_sticky[i] = 1'b0;
      m_cnt[i]    = 0;
      m_hwm[i]    = 0;
      m_last[i]   = '0;
    end
    m_fv    = 1'b0;
    m_fch   = 0;
    m_fdata = '0;
  endtask

  task automatic model_edge(output exp_t e);
    bit ev;
    e.now = '0;
    if (!rst_in) begin
      model_clear(1'b1);
    end else begin
      if (clr_in) model_clear(1'b0);
      for (int i = 0; i < N_CH; i++) begin
        ev = push_in[i] && (count_in[i] == DEPTH);
        e.now[i] = ev;
        if (count_in[i] > m_hwm[i]) m_hwm[i] = count_in[i];
        if (ev) begin
          m_sticky[i] = 1'b1;
          if (m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
          m_last[i] = data_in[i];
          if (!m_fv) begin
            m_fv    = 1'b1;
            m_fch   = i;
            m_fdata = data_in[i];
          end
        end
      end
    end
    for (int i = 0; i < N_CH; i++) e.sticky[i] = m_sticky[i];
    e.irq   = |(e.sticky & mask_in);
    e.fv    = m_fv;
    e.fch   = m_fch;
    e.fdata = m_fdata;
    e.rcnt  = m_cnt[rd_in];
    e.rhwm  = m_hwm[rd_in];
    e.rdata = m_last[rd_in];
  endtask

  task automatic drive();
    for (int i = 0; i < N_CH; i++) begin
      tap_push[i]             = push_in[i];
      tap_count[i*CW +: CW]   = CW'(count_in[i]);
      tap_data[i*PW +: PW]    = data_in[i];
    end
    irq_mask = mask_in;
    clr      = clr_in;
    rd_ch    = IW'(rd_in);
    reset    = rst_in;
  endtask

  task automatic cycle();
    exp_t e;
    drive();
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    for (int i = 0; i < N_CH; i++) begin
      push_in[i]  = 1'b0;
      count_in[i] = 0;
      data_in[i]  = '0;
    end
    clr_in = 1'b0;
  endtask

  task automatic set_ev(input int ch, input logic [PW-1:0] d);
    push_in[ch]  = 1'b1;
    count_in[ch] = DEPTH;
    data_in[ch]  = d;
  endtask

  task automatic clear_all();
    idle();
    clr_in = 1'b1;
    cycle();
    clr_in = 1'b0;
  endtask

  // Monitor: every edge the DUT presents a fresh output set, compared against the oldest prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ovf_now",    ovf_now,    e.now);
        check("ovf_sticky", ovf_sticky, e.sticky);
        check("irq",        irq,        e.irq);
        check("first_vld",  first_vld,  e.fv);
        check("first_ch",   first_ch,   e.fch);
        check("first_data", first_data, e.fdata);
        check("rd_cnt",     rd_cnt,     e.rcnt);
        check("rd_hwm",     rd_hwm,     e.rhwm);
        check("rd_data",    rd_data,    e.rdata);
      end
    end
  end

  initial begin : stimulus
    int r;
    int wait_cnt;
    idle();
    model_clear(1'b1);
    @(negedge clk);

    // Reset held with every channel overflowing, then released.
    rst_in  = 1'b0;
    mask_in = '1;
    for (int i = 0; i < N_CH; i++) set_ev(i, PW'(i + 1));
    repeat (3) cycle();
    check("rst_hold_sticky", ovf_sticky, '0);
    check("rst_hold_first",  first_vld, 1'b0);
    rst_in = 1'b1;
    cycle();
    check("rst_rel_now",    ovf_now, {N_CH{1'b1}});
    check("rst_rel_sticky", ovf_sticky, {N_CH{1'b1}});
    check("rst_rel_first",  first_ch, 0);

    // Single overflow on ch5.
    clear_all();
    set_ev(5, 40'hA5);
    rd_in = 0;
    cycle();
    check("single_now5",    ovf_now[5], 1'b1);
    check("single_irq",     irq, 1'b1);
    check("single_fch",     first_ch, 5);
    check("single_fdata",   first_data, 40'hA5);
    idle();
    rd_in = 5;
    cycle();
    check("single_now5_off", ovf_now[5], 1'b0);
    check("single_sticky5",  ovf_sticky[5], 1'b1);
    check("single_rd_cnt",   rd_cnt, 1);
    check("single_rd_data",  rd_data, 40'hA5);

    // Push below full: no flag, HWM records the occupancy.
    clear_all();
    mask_in = '0;
    mask_in[9] = 1'b1;
    push_in[9] = 1'b1;
    count_in[9] = 3;
    cycle();
    idle();
    rd_in = 9;
    cycle();
    check("nofull_hwm",    rd_hwm, 3);
    check("nofull_irq",    irq, 1'b0);
    check("nofull_sticky", ovf_sticky, '0);

    // Simultaneous events: lowest index wins the first latch.
    clear_all();
    mask_in = '1;
    set_ev(12, 40'h12);
    set_ev(3,  40'h03);
    cycle();
    check("simul_fch",    first_ch, 3);
    check("simul_sticky", ovf_sticky, (64'd1 << 12) | (64'd1 << 3));
    idle();
    set_ev(0, 40'h00);
    cycle();
    check("simul_hold_fch", first_ch, 3);

    // Counter saturation.
    clear_all();
    for (int k = 0; k < 20; k++) begin
      set_ev(7, PW'(k));
      cycle();
    end
    idle();
    rd_in = 7;
    cycle();
    check("sat_rd_cnt", rd_cnt, CNT_MAX);

    // clr with a concurrent event.
    clear_all();
    mask_in = '0;
    mask_in[2] = 1'b1;
    set_ev(2, 40'h22);
    set_ev(8, 40'h88);
    cycle();
    idle();
    cycle();
    clr_in = 1'b1;
    set_ev(2, 40'h2B);
    cycle();
    check("clr_sticky", ovf_sticky, 64'd1 << 2);
    check("clr_fch",    first_ch, 2);
    check("clr_irq",    irq, 1'b1);
    idle();
    rd_in = 2;
    cycle();
    check("clr_cnt2", rd_cnt, 1);
    rd_in = 8;
    cycle();
    check("clr_cnt8", rd_cnt, 0);

    // Reset asserted mid-burst clears at once, without waiting for an edge.
    mask_in = '1;
    for (int i = 0; i < N_CH; i += 5) set_ev(i, PW'(i));
    cycle();
    #1;
    rst_in = 1'b0;
    reset  = 1'b0;
    #1;
    check("midrst_sticky", ovf_sticky, '0);
    check("midrst_irq",    irq, 1'b0);
    check("midrst_first",  first_vld, 1'b0);
    cycle();
    rst_in = 1'b1;
    cycle();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      rst_in  = ($urandom_range(0, 99) != 0);
      clr_in  = ($urandom_range(0, 29) == 0);
      mask_in = {$urandom, $urandom};
      rd_in   = $urandom_range(0, N_CH - 1);
      for (int i = 0; i < N_CH; i++) begin
        push_in[i]  = ($urandom_range(0, 3) == 0);
        r           = $urandom_range(0, 11);
        count_in[i] = (r < 4) ? DEPTH : r - 4;
        data_in[i]  = {8'($urandom), 32'($urandom)};
      end
      cycle();
    end
    idle();
    rst_in = 1'b1;
    cycle();

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb_q.size() > 0) check("scoreboard_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ovf_monitor.md
Name: fifo_ovf_monitor

Overview:
- Parametrised successor to the mesh per-FIFO overflow tap.
- Watches N_CH router-interface FIFOs through their push, count and data taps.
- Adds the following on top of the per-cycle overflow flag and dropped-data capture:
  - sticky flags and an interrupt
  - saturating per-channel event counters
  - per-channel occupancy high-water marks
  - a first-overflow latch
  - an indexed, registered read-out port for the scoreboard

Parameters:
- N_CH, 64, number of monitored FIFOs (mesh 4x4 routers x 4 ports).
- pckg_sz, 40, packet width in bits.
- fifo_depth, 4, depth of each monitored FIFO.
- CNT_W, 16, width of each overflow event counter.
- CW, $clog2(fifo_depth)+1, width of the count taps (localparam).
- IW, $clog2(N_CH), channel index width (localparam).

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low; clears all state.
- tap_push, input, N_CH, push strobe of each FIFO.
- tap_count, input, N_CH*CW, current occupancy; channel i is at [i*CW +: CW].
- tap_data, input, N_CH*pckg_sz, data presented to each FIFO; channel i is at [i*pckg_sz +: pckg_sz].
- irq_mask, input, N_CH, 1 enables channel i onto irq.
- clr, input, 1, synchronous clear pulse for sticky state, counters, HWMs and the first latch.
- rd_ch, input, IW, channel selected for read-out.
- ovf_now, output, N_CH, registered per-cycle overflow flags.
- ovf_sticky, output, N_CH, sticky overflow flags.
- irq, output, 1, interrupt.
- first_vld, output, 1, the first-overflow latch holds a valid record.
- first_ch, output, IW, channel of the first overflow.
- first_data, output, pckg_sz, data dropped at the first overflow.
- rd_cnt, output, CNT_W, event count of rd_ch.
- rd_hwm, output, CW, high-water mark of rd_ch.
- rd_data, output, pckg_sz, last dropped data of rd_ch.

Behaviour:
- Reset (reset=0, asynchronous): every output and all internal state go to 0.
- Overflow event: ev[i] = tap_push[i] && (tap_count[i] == fifo_depth). The event is evaluated combinationally on the taps.
- ovf_now[i] <= ev[i] every cycle, so it asserts for exactly one cycle, one cycle after the push.
- On ev[i], the following update at the same edge:
  - ovf_sticky[i] <= 1
  - cnt[i] <= cnt[i]+1, saturating at 2^CNT_W-1 with no wrap
  - last_data[i] <= tap_data[i]
- Without ev[i], last_data[i] holds.
- HWM: hwm[i] <= max(hwm[i], tap_count[i]) every cycle, regardless of push. Counts above fifo_depth are recorded as-is.
- First-overflow latch:
  - When first_vld=0 and any ev is set, the lowest-index event channel is captured: first_vld<=1, first_ch<=index, first_data<=tap_data of that channel.
  - Once first_vld=1, the latch holds and later events do not disturb it.
- irq is registered: irq <= |(next ovf_sticky & irq_mask). It asserts in the same cycle ovf_sticky rises. A mask change takes effect one cycle later.
- clr=1 at an edge:
  - sticky, cnt, hwm, last_data, first_* and irq are cleared.
  - Any ev in the same cycle is then applied on top: sticky=1, cnt=1, last_data captured, first latch re-captured.
  - hwm is set to tap_count that cycle.
  - ovf_now is unaffected by clr.
- Read-out:
  - rd_cnt, rd_hwm and rd_data are registered, with 1-cycle latency from rd_ch.
  - Read-out reflects state after the same edge's update, i.e. the value of the internal registers at the cycle rd_ch was sampled.
  - If rd_ch >= N_CH, the outputs read 0.
- Simultaneous events on several channels are all counted independently; only the first latch arbitrates, with lowest index winning.
- Reset asserted mid-burst: state clears immediately. Events are ignored while reset=0. Monitoring resumes on the first edge after release.

Test Plan:
- Reset check: hold reset=0 with tap_push all-ones and count=fifo_depth -> all outputs stay 0. Release -> ovf_now and ovf_sticky go to all-ones one cycle later.
- Single overflow: ch5 push with count=4 and data=40'hA5 -> next cycle:
  - ovf_now[5]=1 for 1 cycle; ovf_sticky[5]=1
  - irq=1 with mask bit 5 set
  - first_ch=5, first_data=40'hA5
  - rd_ch=5 -> rd_cnt=1, rd_data=40'hA5 one cycle later.
- Push without overflow: ch9 push with count=3 -> no flag; rd_hwm of ch9 = 3; irq stays 0.
- Simultaneous events: same-cycle events on ch12 and ch3 -> first_ch=3, both sticky bits set. A later event on ch0 leaves first_ch=3.
- Saturation with CNT_W=4: 20 events on ch7 -> rd_cnt=15, with no wrap.
- clr with concurrent event: clr=1 and an event on ch2 in the same cycle, after prior events on ch2 and ch8 ->
  - sticky = only bit 2; cnt[2]=1; cnt[8]=0
  - first_ch=2; irq follows mask bit 2.
